loop_replay_unit: RTL and testbench
===================================

# loop_replay_unit

Read side of the loop buffer. Once the buffering FSM has captured a short backward-branch loop body, this block replays it into the ID stage from buffer memory while fetch is blocked. It always predicts the closing branch taken, checks every resolved closing branch coming back from EX, and on a not-taken or wrong-target outcome raises mispredict, flushes and redirects fetch. It sits between the loop-buffer BRAM and the IF/ID register, beside the buffering FSM.

## Interface
- `LOOP_MAX`, default 32: maximum loop body length in entries, including the closing branch.
- `AW`, default 5: entry address width; must satisfy `2^AW >= LOOP_MAX`.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: pulse; the buffer now holds a complete loop body.
- `loop_len` in 6: body length in entries; sampled when `start` is high.
- `loop_start_pc` in 32: PC of entry 0; sampled when `start` is high.
- `rd_en` out 1: buffer read enable.
- `rd_addr` out AW: buffer entry index.
- `rd_data` in 32: instruction from the buffer; valid one cycle after `rd_en`, held while `rd_en` is low.
- `stall` in 1: ID/EX bubble; the ID stage cannot accept this cycle.
- `out_valid` out 1: `out_instruction`/`out_pc` are valid for ID.
- `out_instruction` out 32: replayed instruction.
- `out_pc` out 32: PC of the replayed instruction.
- `block_fetch` out 1: fetch must hold its PC.
- `ex_valid` in 1: EX is resolving a control-transfer instruction this cycle.
- `ex_pc` in 32: PC of the resolving instruction.
- `ex_taken` in 1: resolved direction.
- `ex_target` in 32: resolved target.
- `mispredict` out 1: one-cycle pulse.
- `flush` out 1: one-cycle pulse, coincident with `mispredict`.
- `redirect_pc` out 32: new fetch PC; valid while `mispredict` is high.
- `iter_count` out 8: completed replay iterations, saturating at 255, cleared on `start`.

## Operation
- Reset: state IDLE; every output is 0.
- States:
  - IDLE:
    - `start` with `1 <= loop_len <= LOOP_MAX` → latch `len`, `base = loop_start_pc`; set `rd_addr = 0`, `rd_en = 1`; go to PRIME.
    - Any other `start` is ignored.
  - PRIME: one cycle of BRAM latency; `block_fetch = 1`; `rd_addr` advances to `1 mod len`; go to ISSUE.
  - ISSUE:
    - `block_fetch = 1`, `out_valid = 1`, `rd_en = !stall`.
    - On each non-stalled cycle, the issue index `idx` advances and `rd_addr` advances, both wrapping `len-1 → 0`.
    - `out_pc = base + {idx, 2'b00}`, computed with 32-bit wrapping addition.
    - `iter_count` increments when issue of entry `len-1` is accepted.
  - EXIT: one cycle; `mispredict = flush = 1`; all other outputs 0; go to IDLE.
- The closing branch is the instruction at `bpc = base + 4*(len-1)`.
- Check, in ISSUE or PRIME, when `ex_valid && ex_pc == bpc`:
  - `!ex_taken` → go to EXIT with `redirect_pc = bpc + 4`.
  - `ex_taken && ex_target != base` → go to EXIT with `redirect_pc = ex_target`.
  - Otherwise continue.
- `ex_valid` with `ex_pc != bpc` is ignored; the body is a basic block.
- `redirect_pc` is held in a register; outputs are registered and reset synchronously.

## Timing
- `start` at cycle T → PRIME at T+1 → first `out_valid` at T+2, carrying entry 0 with `out_pc = base`.
- Throughput: one entry per non-stalled cycle. A stalled cycle holds `out_*`, `rd_addr` and `idx` unchanged.
- Mispredict detected at cycle T → EXIT at T+1 (`mispredict`, `flush`, `redirect_pc` valid, `out_valid = 0`, `block_fetch = 0`) → IDLE at T+2.
- Simultaneous events:
  - Mispredict with `stall`: the mispredict wins.
  - `start` while not in IDLE: ignored.
  - `reset` in any state: IDLE on the next edge; an in-flight EXIT pulse is suppressed.
- `len == 1`: `rd_addr` and `idx` stay 0; every accepted cycle completes one iteration.
- `len == LOOP_MAX`: wraps from `LOOP_MAX-1` to 0.

## Structure
- Shared package holds:
  - the state enum (IDLE, PRIME, ISSUE, EXIT);
  - `LOOP_MAX`;
  - the opcode constants `BTYPE_OPCODE = 7'b1100011` and `JAL_OPCODE = 7'b1101111`, so this block and the buffering FSM use the same definitions.
- One sub-module, `replay_index_ctr`: a modulo-`len` counter with an enable, a wrap pulse and a synchronous clear. It is instantiated twice, once for `rd_addr` and once for `idx`.
- The BRAM is external and shared with the buffering FSM.

## Test plan
- Basic replay: `start`, `len = 4`, `loop_start_pc = 0x100`, buffer holding I0–I3, no stall.
  - Required: `out_valid` from T+2; `out_pc` sequence 0x100, 0x104, 0x108, 0x10C, 0x100, …; `iter_count` increments every 4 cycles.
- Stalls: same setup with `stall` high at cycles T+3 and T+4.
  - Required: I1 / 0x104 held for three cycles, then the sequence resumes without skipping.
- Exit: `len = 3`, `base = 0x200`; `ex_valid`, `ex_pc = 0x208`, `ex_taken = 0`.
  - Required: next cycle `mispredict = flush = 1` with `redirect_pc = 0x20C`; IDLE the cycle after.
- Wrong target: `ex_pc = 0x208`, `ex_taken = 1`, `ex_target = 0x300`.
  - Required: `redirect_pc = 0x300`.
  - Also: `ex_target = 0x200` produces no mispredict.
- Boundaries:
  - `len = 1` → `out_pc` constant at `base`, `iter_count` increments each cycle.
  - `len = 0` or `len = 33` → `start` ignored.
  - `reset` asserted mid-ISSUE → all outputs 0 on the next cycle.
- Saturation: run 300 iterations with `len = 1`.
  - Required: `iter_count` stops at 255.

Source files
------------

// File: rtl/loop_replay_unit_pkg.sv
// Shared definitions for the loop buffer: replay FSM states, buffer depth
// and the opcodes the buffering FSM uses to recognise closing branches.
package loop_replay_unit_pkg;

   // Deepest loop body the buffer can hold, closing branch included.
   localparam int unsigned LOOP_MAX = 32;

   // Control-transfer opcodes that may close a buffered loop.
   localparam logic [6:0] BTYPE_OPCODE = 7'b1100011;
   localparam logic [6:0] JAL_OPCODE   = 7'b1101111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      ISSUE = 2'd2,
      EXIT  = 2'd3
   } replay_state_e;

endpackage

// File: rtl/replay_index_ctr.sv
// Modulo-N index counter: counts 0..last_i and wraps to 0, pulsing wrap_o on
// the enabled cycle that leaves last_i. Synchronous clear takes priority.
module replay_index_ctr #(
   parameter int unsigned AW = 5
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic [AW-1:0] last_i,
   output logic [AW-1:0] count_o,
   output logic          wrap_o
);

   logic [AW-1:0] count_q;
   logic [AW-1:0] count_d;
   logic          at_last;

   assign at_last = (count_q == last_i);

   // Next index: hold, clear, step, or wrap back to zero after last_i.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = at_last ? '0 : count_q + AW'(1);
      end
   end

   // Index register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign wrap_o  = en_i && !clr_i && at_last;

endmodule

// File: rtl/loop_replay_unit.sv
// Read side of the loop buffer. Replays a captured backward-branch loop body
// into ID while fetch is blocked, predicts the closing branch always taken,
// and on a not-taken or wrong-target resolution flushes and redirects fetch.
module loop_replay_unit #(
   parameter int unsigned LOOP_MAX = loop_replay_unit_pkg::LOOP_MAX,
   parameter int unsigned AW       = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [5:0]    loop_len,
   input  logic [31:0]   loop_start_pc,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [31:0]   rd_data,
   input  logic          stall,
   output logic          out_valid,
   output logic [31:0]   out_instruction,
   output logic [31:0]   out_pc,
   output logic          block_fetch,
   input  logic          ex_valid,
   input  logic [31:0]   ex_pc,
   input  logic          ex_taken,
   input  logic [31:0]   ex_target,
   output logic          mispredict,
   output logic          flush,
   output logic [31:0]   redirect_pc,
   output logic [7:0]    iter_count
);

   import loop_replay_unit_pkg::*;

   replay_state_e state_q, state_d;

   logic [5:0]    len_q;
   logic [31:0]   base_q;
   logic [31:0]   bpc_q;
   logic [31:0]   redirect_q, redirect_d;
   logic [7:0]    iter_q;

   logic          start_ok;
   logic          closing_hit;
   logic          bad_outcome;
   logic          checking;
   logic          accept;

   logic [AW-1:0] last_idx;
   logic          rd_step;
   logic [AW-1:0] rd_cnt;
   logic          rd_wrap;
   logic [AW-1:0] idx_cnt;
   logic          idx_wrap;

   // A start is only honoured from IDLE and with a body length that fits.
   assign start_ok = (state_q == IDLE) && start && (loop_len != 6'd0)
                     && (32'(loop_len) <= LOOP_MAX);

   // The closing branch is resolved while priming or issuing; anything else
   // resolving in EX lies inside the basic block and is not our concern.
   assign checking    = (state_q == PRIME) || (state_q == ISSUE);
   assign closing_hit = checking && ex_valid && (ex_pc == bpc_q);
   assign bad_outcome = closing_hit && (!ex_taken || (ex_target != base_q));

   // An issue slot is consumed only when ID can take it.
   assign accept   = (state_q == ISSUE) && !stall;
   assign rd_step  = (state_q == PRIME) || accept;
   assign last_idx = AW'(len_q - 6'd1);

   // Buffer read pointer: runs one entry ahead of the issue index because
   // the BRAM output lags its address by a cycle.
   replay_index_ctr #(
      .AW (AW)
   ) u_rd_ctr (
      .clk_i   (clk),
      .reset_i (reset),
      .clr_i   (start_ok),
      .en_i    (rd_step),
      .last_i  (last_idx),
      .count_o (rd_cnt),
      .wrap_o  (rd_wrap)
   );

   // Issue index: selects the PC of the instruction currently shown to ID.
   replay_index_ctr #(
      .AW (AW)
   ) u_idx_ctr (
      .clk_i   (clk),
      .reset_i (reset),
      .clr_i   (start_ok),
      .en_i    (accept),
      .last_i  (last_idx),
      .count_o (idx_cnt),
      .wrap_o  (idx_wrap)
   );

   // Next state and redirect target; a bad closing-branch outcome overrides
   // a concurrent stall.
   always_comb begin
      state_d    = state_q;
      redirect_d = redirect_q;
      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = PRIME;
            end
         end
         PRIME, ISSUE: begin
            if (bad_outcome) begin
               state_d    = EXIT;
               redirect_d = ex_taken ? ex_target : bpc_q + 32'd4;
            end else begin
               state_d = ISSUE;
            end
         end
         EXIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and redirect registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         redirect_q <= '0;
      end else begin
         state_q    <= state_d;
         redirect_q <= redirect_d;
      end
   end

   // Loop geometry captured at start; the closing-branch PC is precomputed
   // so the EX compare is a single equality.
   always_ff @(posedge clk) begin
      if (reset) begin
         len_q  <= '0;
         base_q <= '0;
         bpc_q  <= '0;
      end else if (start_ok) begin
         len_q  <= loop_len;
         base_q <= loop_start_pc;
         bpc_q  <= loop_start_pc + {24'd0, loop_len - 6'd1, 2'b00};
      end
   end

   // Completed-iteration counter, saturating, cleared by an accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         iter_q <= '0;
      end else if (start_ok) begin
         iter_q <= '0;
      end else if (idx_wrap && (iter_q != 8'hFF)) begin
         iter_q <= iter_q + 8'd1;
      end
   end

   // Output decode from registered state. rd_en follows stall in the same
   // cycle so that the BRAM output register holds the stalled instruction.
   always_comb begin
      rd_en           = 1'b0;
      rd_addr         = '0;
      out_valid       = 1'b0;
      out_instruction = '0;
      out_pc          = '0;
      block_fetch     = 1'b0;
      mispredict      = 1'b0;
      flush           = 1'b0;
      redirect_pc     = '0;
      unique case (state_q)
         PRIME: begin
            rd_en       = 1'b1;
            rd_addr     = rd_cnt;
            block_fetch = 1'b1;
         end
         ISSUE: begin
            rd_en           = !stall;
            rd_addr         = rd_cnt;
            block_fetch     = 1'b1;
            out_valid       = 1'b1;
            out_instruction = rd_data;
            out_pc          = base_q + 32'({idx_cnt, 2'b00});
         end
         EXIT: begin
            mispredict  = 1'b1;
            flush       = 1'b1;
            redirect_pc = redirect_q;
         end
         default: begin
         end
      endcase
   end

   assign iter_count = iter_q;

endmodule

// File: tb/tb_loop_replay_unit.sv
// Directed bench for loop_replay_unit with a small BRAM model.
module tb_loop_replay_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  loop_len = '0;
   logic [31:0] loop_start_pc = '0;
   logic        rd_en;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data = '0;
   logic        stall = 1'b0;
   logic        out_valid;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   logic        block_fetch;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = '0;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = '0;
   logic        mispredict;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [7:0]  iter_count;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem [0:31];

   always #5 clk = ~clk;

   loop_replay_unit #(
      .LOOP_MAX (32),
      .AW       (5)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .loop_len        (loop_len),
      .loop_start_pc   (loop_start_pc),
      .rd_en           (rd_en),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .stall           (stall),
      .out_valid       (out_valid),
      .out_instruction (out_instruction),
      .out_pc          (out_pc),
      .block_fetch     (block_fetch),
      .ex_valid        (ex_valid),
      .ex_pc           (ex_pc),
      .ex_taken        (ex_taken),
      .ex_target       (ex_target),
      .mispredict      (mispredict),
      .flush           (flush),
      .redirect_pc     (redirect_pc),
      .iter_count      (iter_count)
   );

   // Loop-buffer BRAM: one-cycle read latency, output held while rd_en low.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b1; start = 1'b0; stall = 1'b0; ex_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   // Pulse start for one cycle; returns at the negedge of the PRIME cycle.
   task automatic launch(input logic [5:0] len, input logic [31:0] pc);
      start = 1'b1; loop_len = len; loop_start_pc = pc;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      #1;
      vectors++;
      if ({rd_en, out_valid, block_fetch, mispredict, flush} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b want 00000", {rd_en, out_valid, block_fetch, mispredict, flush});
      end
      vectors++;
      if ({rd_addr, out_instruction, out_pc, redirect_pc, iter_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: rd_addr=%h instr=%h pc=%h redir=%h iter=%0d want all 0",
                  rd_addr, out_instruction, out_pc, redirect_pc, iter_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      apply_reset();
      launch(6'd4, 32'h100);
      #1;
      vectors++;
      if ({rd_en, rd_addr, block_fetch, out_valid} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_prime: rd_en=%b rd_addr=%0d bf=%b ov=%b want 1 0 1 0",
                  rd_en, rd_addr, block_fetch, out_valid);
      end
      tick();
      for (int k = 0; k < 10; k++) begin
         #1;
         vectors++;
         if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * (k % 4))) begin
            miscompares++;
            $display("FAIL basic_pc[%0d]: ov=%b pc=%h want 1 %h", k, out_valid, out_pc, 32'h100 + 32'(4 * (k % 4)));
         end
         vectors++;
         if (out_instruction !== mem[k % 4]) begin
            miscompares++;
            $display("FAIL basic_instr[%0d]: got %h want %h", k, out_instruction, mem[k % 4]);
         end
         vectors++;
         if (iter_count !== 8'(k / 4)) begin
            miscompares++;
            $display("FAIL basic_iter[%0d]: got %0d want %0d", k, iter_count, k / 4);
         end
         tick();
      end
   endtask

   task automatic test_stalls();
      int  exp_idx [8] = '{0, 1, 1, 1, 2, 3, 0, 1};
      logic st     [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      apply_reset();
      launch(6'd4, 32'h100);
      tick();
      for (int k = 0; k < 8; k++) begin
         stall = st[k];
         #1;
         vectors++;
         if (out_pc !== 32'h100 + 32'(4 * exp_idx[k]) || out_instruction !== mem[exp_idx[k]]) begin
            miscompares++;
            $display("FAIL stall_out[%0d]: pc=%h instr=%h want %h %h", k, out_pc, out_instruction,
                     32'h100 + 32'(4 * exp_idx[k]), mem[exp_idx[k]]);
         end
         vectors++;
         if (rd_en !== !st[k]) begin
            miscompares++;
            $display("FAIL stall_rden[%0d]: got %b want %b", k, rd_en, !st[k]);
         end
         tick();
      end
      stall = 1'b0;
   endtask

   task automatic test_exit();
      apply_reset();
      launch(6'd3, 32'h200);
      tick();
      ex_valid = 1'b1; ex_pc = 32'h204; ex_taken = 1'b0;
      tick();
      ex_valid = 1'b0;
      #1;
      vectors++;
      if (mispredict !== 1'b0 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL exit_nonclosing: mp=%b ov=%b want 0 1", mispredict, out_valid);
      end
      ex_valid = 1'b1; ex_pc = 32'h208; ex_taken = 1'b0;
      tick();
      ex_valid = 1'b0;
      #1;
      vectors++;
      if ({mispredict, flush} !== 2'b11 || redirect_pc !== 32'h20C) begin
         miscompares++;
         $display("FAIL exit_pulse: mp=%b fl=%b redir=%h want 1 1 0000020c", mispredict, flush, redirect_pc);
      end
      vectors++;
      if ({out_valid, block_fetch, rd_en} !== 3'b000) begin
         miscompares++;
         $display("FAIL exit_quiet: ov=%b bf=%b rd_en=%b want 000", out_valid, block_fetch, rd_en);
      end
      tick();
      #1;
      vectors++;
      if ({mispredict, flush, block_fetch, out_valid} !== 4'b0 || redirect_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL exit_idle: mp=%b fl=%b bf=%b ov=%b redir=%h want all 0",
                  mispredict, flush, block_fetch, out_valid, redirect_pc);
      end
      launch(6'd3, 32'h200);
      #1;
      vectors++;
      if (block_fetch !== 1'b1) begin
         miscompares++;
         $display("FAIL exit_restart: bf=%b want 1", block_fetch);
      end
   endtask

   task automatic test_wrong_target();
      apply_reset();
      launch(6'd3, 32'h200);
      tick();
      ex_valid = 1'b1; ex_pc = 32'h208; ex_taken = 1'b1; ex_target = 32'h200;
      tick();
      ex_valid = 1'b0;
      #1;
      vectors++;
      if (mispredict !== 1'b0 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL wt_correct: mp=%b ov=%b want 0 1", mispredict, out_valid);
      end
      stall = 1'b1;
      ex_valid = 1'b1; ex_pc = 32'h208; ex_taken = 1'b1; ex_target = 32'h300;
      tick();
      ex_valid = 1'b0; stall = 1'b0;
      #1;
      vectors++;
      if (mispredict !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h300) begin
         miscompares++;
         $display("FAIL wt_redirect: mp=%b fl=%b redir=%h want 1 1 00000300", mispredict, flush, redirect_pc);
      end
      tick();
   endtask

   task automatic test_len_one();
      apply_reset();
      launch(6'd1, 32'h400);
      tick();
      for (int k = 0; k < 6; k++) begin
         #1;
         vectors++;
         if (out_pc !== 32'h400 || rd_addr !== 5'd0 || out_instruction !== mem[0]) begin
            miscompares++;
            $display("FAIL len1_out[%0d]: pc=%h rd_addr=%0d instr=%h want 00000400 0 %h",
                     k, out_pc, rd_addr, out_instruction, mem[0]);
         end
         vectors++;
         if (iter_count !== 8'(k)) begin
            miscompares++;
            $display("FAIL len1_iter[%0d]: got %0d want %0d", k, iter_count, k);
         end
         tick();
      end
   endtask

   task automatic test_bad_len();
      logic [5:0] bad [2] = '{6'd0, 6'd33};
      for (int i = 0; i < 2; i++) begin
         apply_reset();
         launch(bad[i], 32'h500);
         #1;
         vectors++;
         if ({block_fetch, rd_en, out_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL badlen_%0d: bf=%b rd_en=%b ov=%b want 000", bad[i], block_fetch, rd_en, out_valid);
         end
         tick();
         #1;
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL badlen_%0d_ov: got %b want 0", bad[i], out_valid);
         end
      end
   endtask

   task automatic test_ignored_start();
      apply_reset();
      launch(6'd4, 32'h100);
      tick(); tick();
      start = 1'b1; loop_len = 6'd2; loop_start_pc = 32'h900;
      tick();
      start = 1'b0;
      #1;
      vectors++;
      if (out_pc !== 32'h108) begin
         miscompares++;
         $display("FAIL busy_start_a: pc=%h want 00000108", out_pc);
      end
      tick();
      #1;
      vectors++;
      if (out_pc !== 32'h10C || out_instruction !== mem[3]) begin
         miscompares++;
         $display("FAIL busy_start_b: pc=%h instr=%h want 0000010c %h", out_pc, out_instruction, mem[3]);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      launch(6'd4, 32'h100);
      tick();
      repeat (6) tick();
      #1;
      vectors++;
      if (iter_count !== 8'd1 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rmid_pre: iter=%0d ov=%b want 1 1", iter_count, out_valid);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      vectors++;
      if ({rd_en, out_valid, block_fetch, mispredict, flush} !== 5'b0 ||
          {rd_addr, out_instruction, out_pc, redirect_pc, iter_count} !== '0) begin
         miscompares++;
         $display("FAIL rmid_outs: ctl=%b rd_addr=%0d instr=%h pc=%h redir=%h iter=%0d want all 0",
                  {rd_en, out_valid, block_fetch, mispredict, flush}, rd_addr, out_instruction,
                  out_pc, redirect_pc, iter_count);
      end
   endtask

   task automatic test_len_max();
      apply_reset();
      launch(6'd32, 32'h0);
      tick();
      for (int k = 0; k < 34; k++) begin
         #1;
         vectors++;
         if (out_pc !== 32'(4 * (k % 32)) || out_instruction !== mem[k % 32]) begin
            miscompares++;
            $display("FAIL lmax[%0d]: pc=%h instr=%h want %h %h", k, out_pc, out_instruction,
                     32'(4 * (k % 32)), mem[k % 32]);
         end
         if (k == 32) begin
            vectors++;
            if (iter_count !== 8'd1) begin
               miscompares++;
               $display("FAIL lmax_iter: got %0d want 1", iter_count);
            end
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      int exp;
      apply_reset();
      launch(6'd1, 32'h40);
      tick();
      for (int k = 0; k < 300; k++) begin
         exp = (k > 255) ? 255 : k;
         #1;
         vectors++;
         if (iter_count !== 8'(exp)) begin
            miscompares++;
            $display("FAIL sat[%0d]: got %0d want %0d", k, iter_count, exp);
         end
         tick();
      end
      #1;
      vectors++;
      if (iter_count !== 8'd255) begin
         miscompares++;
         $display("FAIL sat_final: got %0d want 255", iter_count);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 17 + 3);
      tick();
      test_reset();
      test_basic();
      test_stalls();
      test_exit();
      test_wrong_target();
      test_len_one();
      test_bad_len();
      test_ignored_start();
      test_reset_mid();
      test_len_max();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
